// File: rtl/mem_io_pkg.sv
// Shared address map, TCTRL bit positions, reset values and the address decoder
// for the mem_io_bridge load/store bridge.
package mem_io_pkg;

    localparam logic [31:0] LED_ADDR    = 32'hFFFF_0000;
    localparam logic [31:0] TCOUNT_ADDR = 32'hFFFF_0004;
    localparam logic [31:0] TCMP_ADDR   = 32'hFFFF_0008;
    localparam logic [31:0] TCTRL_ADDR  = 32'hFFFF_000C;

    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_AUTO = 1;
    localparam int TCTRL_FLAG = 2;
    localparam int TCTRL_IE   = 3;

    localparam logic [7:0]  LED_RST    = 8'h00;
    localparam logic [31:0] TCOUNT_RST = 32'h0000_0000;
    localparam logic [31:0] TCMP_RST   = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_TCOUNT,
        SEL_TCMP,
        SEL_TCTRL
    } sel_t;

    // Word-granular decode: the byte offset in addr[1:0] never matters.
    function automatic sel_t decode(input logic [31:0] addr, input int ram_words);
        logic [29:0] word;
        word = addr[31:2];
        if ({2'b00, word} < 32'(ram_words))  return SEL_RAM;
        if (word == LED_ADDR[31:2])          return SEL_LED;
        if (word == TCOUNT_ADDR[31:2])       return SEL_TCOUNT;
        if (word == TCMP_ADDR[31:2])         return SEL_TCMP;
        if (word == TCTRL_ADDR[31:2])        return SEL_TCTRL;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Data RAM: WORDS x 32, asynchronous read, synchronous write, no reset
// so contents survive a bridge reset.
module dmem_ram #(
    parameter int WORDS = 64,
    localparam int AW   = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_io_bridge.sv
// Memory/IO bridge for a single-cycle core: data RAM, LED register and an optional
// compare timer enabled by defining MEM_IO_TIMER_EN.
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int RAM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  led,
    output logic        irq
);

    localparam int AW = $clog2(RAM_WORDS);

    sel_t        sel;
    logic [31:0] ram_rdata;
    logic [31:0] tcount_rd;
    logic [31:0] tcmp_rd;
    logic [31:0] tctrl_rd;

    assign sel = decode(aluout, RAM_WORDS);

    dmem_ram #(.WORDS(RAM_WORDS)) u_ram (
        .clk   (clk),
        .we    (memwrite && (sel == SEL_RAM)),
        .addr  (aluout[AW+1:2]),
        .wdata (writedata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              led <= LED_RST;
        else if (memwrite && (sel == SEL_LED))   led <= writedata[7:0];
    end

`ifdef MEM_IO_TIMER_EN
    logic [31:0] tcount;
    logic [31:0] tcmp;
    logic        en, auto_rl, flag, ie;
    logic        match, wr_tcmp, wr_tctrl;

    assign match    = en && (tcount == tcmp);
    assign wr_tcmp  = memwrite && (sel == SEL_TCMP);
    assign wr_tctrl = memwrite && (sel == SEL_TCTRL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcount  <= TCOUNT_RST;
            tcmp    <= TCMP_RST;
            en      <= 1'b0;
            auto_rl <= 1'b0;
            flag    <= 1'b0;
            ie      <= 1'b0;
        end else begin
            if (wr_tcmp) tcmp <= writedata;

            // Match takes priority over both the FLAG W1C and a software EN write.
            if (match && !auto_rl)  en <= 1'b0;
            else if (wr_tctrl)      en <= writedata[TCTRL_EN];

            if (match)                                flag <= 1'b1;
            else if (wr_tctrl && writedata[TCTRL_FLAG]) flag <= 1'b0;

            if (wr_tctrl) begin
                auto_rl <= writedata[TCTRL_AUTO];
                ie      <= writedata[TCTRL_IE];
            end

            // Count is only idle (en=0) in the start-from-zero branch, so the cases are disjoint.
            if (match) begin
                if (auto_rl) tcount <= '0;
            end else if (en) begin
                tcount <= tcount + 32'd1;
            end else if (wr_tctrl && writedata[TCTRL_EN]) begin
                tcount <= '0;
            end
        end
    end

    assign tcount_rd = tcount;
    assign tcmp_rd   = tcmp;
    assign tctrl_rd  = {28'd0, ie, flag, auto_rl, en};
    assign irq       = flag & ie;
`else
    assign tcount_rd = '0;
    assign tcmp_rd   = '0;
    assign tctrl_rd  = '0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (sel)
            SEL_RAM:    readdata = ram_rdata;
            SEL_LED:    readdata = {24'd0, led};
            SEL_TCOUNT: readdata = tcount_rd;
            SEL_TCMP:   readdata = tcmp_rd;
            SEL_TCTRL:  readdata = tctrl_rd;
            default:    readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed self-checking bench for mem_io_bridge; timer checks follow MEM_IO_TIMER_EN.
module tb_mem_io_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] aluout = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  led;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] A_LED    = 32'hFFFF_0000;
    localparam logic [31:0] A_TCOUNT = 32'hFFFF_0004;
    localparam logic [31:0] A_TCMP   = 32'hFFFF_0008;
    localparam logic [31:0] A_TCTRL  = 32'hFFFF_000C;

    mem_io_bridge #(.RAM_WORDS(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .led       (led),
        .irq       (irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        aluout    = a;
        writedata = d;
        memwrite  = 1'b1;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        aluout = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    initial begin
        // Reset state, checked while reset is held low and before any clock edge.
        #2;
        chk("rst_led", {24'd0, led}, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        rd("rst_tcount", A_TCOUNT, 32'h0);
`ifdef MEM_IO_TIMER_EN
        rd("rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
`else
        rd("rst_tcmp", A_TCMP, 32'h0);
`endif
        rd("rst_tctrl", A_TCTRL, 32'h0);
        reset = 1'b1;
        tick();

        // RAM store/load, byte offset ignored.
        wr(32'h10, 32'h1234_5678);
        rd("ram_ld_10", 32'h10, 32'h1234_5678);
        rd("ram_ld_13", 32'h13, 32'h1234_5678);

        // Load in the store cycle sees the old value.
        aluout = 32'h10; writedata = 32'hCAFE_BABE; memwrite = 1'b1;
        #1;
        chk("ram_same_cycle_old", readdata, 32'h1234_5678);
        tick();
        memwrite = 1'b0;
        rd("ram_after_store", 32'h10, 32'hCAFE_BABE);
        wr(32'h10, 32'h1234_5678);

        // RAM bounds: last word usable, first word past the end must not alias word 0.
        wr(32'h0, 32'h1111_1111);
        wr(32'hFC, 32'h3333_3333);
        wr(32'h100, 32'h2222_2222);
        rd("ram_word0", 32'h0, 32'h1111_1111);
        rd("ram_last_word", 32'hFF, 32'h3333_3333);
        rd("ram_past_end", 32'h100, 32'h0);

        // LED register and unmapped space.
        wr(A_LED, 32'hABCD_EF5A);
        chk("led_out", {24'd0, led}, 32'h5A);
        rd("led_rd", A_LED, 32'h0000_005A);
        wr(32'h0000_4000, 32'hDEAD_BEEF);
        rd("unmapped_4000", 32'h0000_4000, 32'h0);
        rd("unmapped_no_alias", 32'h0, 32'h1111_1111);
        rd("unmapped_ffff0010", 32'hFFFF_0010, 32'h0);

`ifdef MEM_IO_TIMER_EN
        // Auto-reload: TCMP=5, EN|AUTO|IE.
        wr(A_TCMP, 32'd5);
        rd("tcmp_rd", A_TCMP, 32'd5);
        wr(A_TCTRL, 32'h0B);
        rd("auto_cnt0", A_TCOUNT, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            rd($sformatf("auto_cnt%0d", i), A_TCOUNT, 32'(i));
            chk($sformatf("auto_irq_lo%0d", i), {31'd0, irq}, 32'h0);
        end
        tick();
        rd("auto_reload0", A_TCOUNT, 32'd0);
        chk("auto_irq_hi", {31'd0, irq}, 32'h1);
        rd("auto_tctrl", A_TCTRL, 32'h0F);
        tick();
        rd("auto_continues", A_TCOUNT, 32'd1);
        wr(A_TCTRL, 32'h04);
        chk("auto_stop_irq", {31'd0, irq}, 32'h0);

        // One-shot: TCMP=3, EN|IE.
        wr(A_TCMP, 32'd3);
        wr(A_TCTRL, 32'h09);
        rd("os_start0", A_TCOUNT, 32'd0);
        tick(); tick(); tick();
        rd("os_cnt3", A_TCOUNT, 32'd3);
        chk("os_irq_pre", {31'd0, irq}, 32'h0);
        tick();
        rd("os_hold3", A_TCOUNT, 32'd3);
        chk("os_irq_hi", {31'd0, irq}, 32'h1);
        rd("os_tctrl", A_TCTRL, 32'h0C);
        tick();
        rd("os_still3", A_TCOUNT, 32'd3);
        wr(A_TCOUNT, 32'd77);
        rd("tcount_ro", A_TCOUNT, 32'd3);
        wr(A_TCTRL, 32'h04);
        chk("os_irq_clr", {31'd0, irq}, 32'h0);
        rd("os_tctrl_clr", A_TCTRL, 32'h0);

        // W1C and EN=1 written in the exact match cycle: hardware wins both.
        wr(A_TCMP, 32'd2);
        wr(A_TCTRL, 32'h01);
        tick(); tick();
        rd("w1c_at_match", A_TCOUNT, 32'd2);
        wr(A_TCTRL, 32'h05);
        rd("w1c_flag_kept", A_TCTRL, 32'h04);
        tick();
        rd("w1c_en_cleared", A_TCOUNT, 32'd2);
        wr(A_TCTRL, 32'h04);
        rd("w1c_later_clr", A_TCTRL, 32'h0);

        // Get the timer running with irq high before the mid-cycle reset.
        wr(A_TCMP, 32'd2);
        wr(A_TCTRL, 32'h0B);
        tick(); tick(); tick(); tick();
        rd("pre_rst_cnt", A_TCOUNT, 32'd1);
        chk("pre_rst_irq", {31'd0, irq}, 32'h1);
`else
        // Timer absent: registers read zero, writes ignored, irq stays low.
        wr(A_TCMP, 32'd5);
        wr(A_TCTRL, 32'h0B);
        for (int i = 0; i < 8; i++) tick();
        rd("notimer_tcount", A_TCOUNT, 32'h0);
        rd("notimer_tcmp", A_TCMP, 32'h0);
        rd("notimer_tctrl", A_TCTRL, 32'h0);
        chk("notimer_irq", {31'd0, irq}, 32'h0);
`endif

        // Asynchronous reset between clock edges.
        chk("pre_rst_led", {24'd0, led}, 32'h5A);
        aluout = A_TCOUNT;
        #3;
        reset = 1'b0;
        #1;
        chk("rst_async_tcount", readdata, 32'h0);
        chk("rst_async_led", {24'd0, led}, 32'h0);
        chk("rst_async_irq", {31'd0, irq}, 32'h0);
        rd("rst_ram_kept", 32'h10, 32'h1234_5678);
        reset = 1'b1;
        tick();
        rd("post_rst_stopped", A_TCOUNT, 32'h0);
        rd("post_rst_tctrl", A_TCTRL, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 64, data RAM depth in 32-bit words (power of two, 16..256).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port memwrite  input  1  store strobe from the core, one store per asserted cycle.
REQ-005 SHALL have port aluout  input  32  byte address from the core.
REQ-006 SHALL have port writedata  input  32  store data from the core.
REQ-007 SHALL have port readdata  output  32  load data returned to the core.
REQ-008 SHALL have port led  output  8  LED register contents.
REQ-009 SHALL have port irq  output  1  timer interrupt request, level.

Function
REQ-010 SHALL decode word addresses, ignoring aluout[1:0]: RAM at 0x0000_0000..(RAM_WORDS*4-1); LED 0xFFFF_0000; TCOUNT 0xFFFF_0004 (RO); TCMP 0xFFFF_0008 (RW); TCTRL 0xFFFF_000C.
REQ-011 SHALL drive readdata combinationally from aluout in the same cycle (zero-latency load, single-cycle core).
REQ-012 SHALL commit writes on the rising edge where memwrite=1; a read in the same cycle returns the pre-write value.
REQ-013 SHALL return 0 for unmapped reads and ignore unmapped writes, including writes to TCOUNT.
REQ-014 SHALL read LED as {24'b0, led}; writes take writedata[7:0].
REQ-015 SHALL define TCTRL bits: [0] EN, [1] AUTO (auto-reload), [2] FLAG (match, write-1-to-clear), [3] IE; other bits read 0.
REQ-016 SHALL increment TCOUNT by 1 each cycle while EN=1, wrapping 0xFFFF_FFFF -> 0.
REQ-017 SHALL, on a cycle with EN=1 and TCOUNT==TCMP: set FLAG; if AUTO=1, load TCOUNT=0 next cycle and stay enabled; if AUTO=0, clear EN and hold TCOUNT.
REQ-018 SHALL let a match-set win over a same-cycle FLAG W1C.
REQ-019 SHALL let hardware EN-clear on one-shot match win over a same-cycle software write of EN=1.
REQ-020 SHALL clear TCOUNT to 0 on any TCTRL write with writedata[0]=1 while EN=0 (start from zero).
REQ-021 SHALL drive irq = FLAG & IE, registered-state derived, no combinational path from inputs.

Reset
REQ-022 SHALL, while reset=0, force led=0, TCOUNT=0, TCMP=0xFFFF_FFFF, TCTRL=0, irq=0, independent of clk.
REQ-023 SHALL NOT reset RAM contents; reset mid-count stops the timer immediately.

Configuration
REQ-024 SHALL honour macro MEM_IO_TIMER_EN: defined -> timer per REQ-015..021; undefined -> TCOUNT/TCMP/TCTRL read 0, writes ignored, irq tied 0, no timer flops.

Structure
REQ-025 SHALL place address map constants, TCTRL bit indices and reset values in shared package mem_io_pkg.
REQ-026 SHALL instantiate one sub-module dmem_ram (RAM_WORDS x 32, async read, sync write).

Verification
REQ-027 SHALL cover: store 0x1234_5678 to 0x10, load 0x10 next cycle -> readdata=0x1234_5678; load 0x13 -> same.
REQ-028 SHALL cover: store 0xABCD_EF5A to 0xFFFF_0000 -> led=0x5A, read -> 0x0000_005A; store to 0x0000_4000 -> no RAM change, read 0.
REQ-029 SHALL cover: TCMP=5, TCTRL=0x0B -> TCOUNT 0..5, FLAG and irq high after count 5, TCOUNT back to 0, counting continues.
REQ-030 SHALL cover: TCMP=3, TCTRL=0x09 (one-shot) -> EN clears, TCOUNT holds 3; write TCTRL=0x04 -> FLAG and irq clear.
REQ-031 SHALL cover: W1C of FLAG in the exact match cycle -> FLAG remains 1.
REQ-032 SHALL cover: reset=0 asserted mid-count between clk edges -> TCOUNT=0, led=0, irq=0 immediately; RAM word at 0x10 retained.
